cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_pkg.sv | 30 +++
 rtl/cache_line_array.sv | 49 ++++
 rtl/cache_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared command codes, field ranges, sizes and FSM encoding
package cache_controller_pkg;

    localparam int REQ_W     = 25;
    localparam int CMD_HI    = 24;
    localparam int CMD_LO    = 23;
    localparam int ADDR_HI   = 22;
    localparam int ADDR_LO   = 7;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int NUM_LINES = 16;
    localparam int IDX_W     = 4;
    localparam int TAG_W     = 12;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ_MISS = 2'd1,
        S_WRITE_MEM = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    function automatic logic [REQ_W-1:0] make_req(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr);
        return {cmd, addr, {ADDR_LO{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - direct-mapped line storage: lookup, write and invalidate ports
// A write in the same cycle as an invalidate of the same line wins.
module cache_line_array
    import cache_controller_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_lk_idx,
    output logic              o_lk_valid,
    output logic [TAG_W-1:0]  o_lk_tag,
    output logic [DATA_W-1:0] o_lk_data,
    input  logic              i_wr_en,
    input  logic              i_wr_valid,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_inv_en,
    input  logic [IDX_W-1:0]  i_inv_idx,
    input  logic [TAG_W-1:0]  i_inv_tag
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [DATA_W-1:0]    r_data [NUM_LINES];

    assign o_lk_valid = r_valid[i_lk_idx];
    assign o_lk_tag   = r_tag[i_lk_idx];
    assign o_lk_data  = r_data[i_lk_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_inv_en && r_valid[i_inv_idx] && (r_tag[i_inv_idx] == i_inv_tag)) begin
                r_valid[i_inv_idx] <= 1'b0;
            end
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= i_wr_valid;
                r_tag[i_wr_idx]   <= i_wr_tag;
                r_data[i_wr_idx]  <= i_wr_data;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-allocate, write-through direct-mapped cache controller
// Forwards writes to memory and notifies the coherence stage on write completion.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [REQ_W-1:0]  cpu_request,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [REQ_W-1:0]  mem_request,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [REQ_W-1:0]  cache_change,
    input  logic [ADDR_W-1:0] cache_invalidate
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last_inv;
    logic                r_fill_killed;
    logic                r_cpu_ready;
    logic                r_cpu_done;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [REQ_W-1:0]    r_mem_request;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [REQ_W-1:0]    r_cache_change;

    logic [1:0]          w_cmd;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_idle, w_acc_rd, w_acc_wr, w_fill, w_hit;
    logic                w_inv_en, w_inv_hits_fill;
    logic                w_lk_valid;
    logic [TAG_W-1:0]    w_lk_tag;
    logic [DATA_W-1:0]   w_lk_data;
    logic                w_wr_en, w_wr_valid;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [TAG_W-1:0]    w_wr_tag;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_unused;

    assign w_unused = ^cpu_request[ADDR_LO-1:0];
    assign w_cmd    = cpu_request[CMD_HI:CMD_LO];
    assign w_addr   = cpu_request[ADDR_HI:ADDR_LO];
    assign w_idle   = (r_state == S_IDLE);
    assign w_acc_rd = w_idle && (w_cmd == CMD_READ);
    assign w_acc_wr = w_idle && (w_cmd == CMD_WRITE);
    assign w_fill   = (r_state == S_READ_MISS) && mem_ack;
    assign w_hit    = w_lk_valid && (w_lk_tag == w_addr[ADDR_W-1:IDX_W]);

    // Invalidates are level-held; only a change of value is an event.
    assign w_inv_en        = (cache_invalidate != r_last_inv);
    assign w_inv_hits_fill = w_inv_en && (cache_invalidate == r_addr);

    assign w_wr_en    = w_acc_wr || w_fill;
    assign w_wr_valid = w_acc_wr || !(r_fill_killed || w_inv_hits_fill);
    assign w_wr_idx   = w_acc_wr ? w_addr[IDX_W-1:0] : r_addr[IDX_W-1:0];
    assign w_wr_tag   = w_acc_wr ? w_addr[ADDR_W-1:IDX_W] : r_addr[ADDR_W-1:IDX_W];
    assign w_wr_data  = w_acc_wr ? cpu_wdata : mem_rdata;

    cache_line_array u_lines (
        .clock      (clock),
        .reset      (reset),
        .i_lk_idx   (w_addr[IDX_W-1:0]),
        .o_lk_valid (w_lk_valid),
        .o_lk_tag   (w_lk_tag),
        .o_lk_data  (w_lk_data),
        .i_wr_en    (w_wr_en),
        .i_wr_valid (w_wr_valid),
        .i_wr_idx   (w_wr_idx),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data),
        .i_inv_en   (w_inv_en),
        .i_inv_idx  (cache_invalidate[IDX_W-1:0]),
        .i_inv_tag  (cache_invalidate[ADDR_W-1:IDX_W])
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_last_inv     <= '0;
            r_fill_killed  <= 1'b0;
            r_cpu_ready    <= 1'b1;
            r_cpu_done     <= 1'b0;
            r_cpu_rdata    <= '0;
            r_mem_request  <= make_req(CMD_NOP, '0);
            r_mem_wdata    <= '0;
            r_cache_change <= make_req(CMD_NOP, '0);
        end else begin
            r_last_inv <= cache_invalidate;
            case (r_state)
                S_IDLE: begin
                    r_fill_killed <= 1'b0;
                    if (w_acc_rd || w_acc_wr) begin
                        r_addr      <= w_addr;
                        r_cpu_ready <= 1'b0;
                    end
                    if (w_acc_wr) begin
                        r_state       <= S_WRITE_MEM;
                        r_mem_request <= make_req(CMD_WRITE, w_addr);
                        r_mem_wdata   <= cpu_wdata;
                    end else if (w_acc_rd && w_hit) begin
                        r_state     <= S_RESPOND;
                        r_cpu_done  <= 1'b1;
                        r_cpu_rdata <= w_lk_data;
                    end else if (w_acc_rd) begin
                        r_state       <= S_READ_MISS;
                        r_mem_request <= make_req(CMD_READ, w_addr);
                    end
                end
                S_READ_MISS: begin
                    if (w_inv_hits_fill) begin
                        r_fill_killed <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_state       <= S_RESPOND;
                        r_mem_request <= make_req(CMD_NOP, '0);
                        r_cpu_done    <= 1'b1;
                        r_cpu_rdata   <= mem_rdata;
                    end
                end
                S_WRITE_MEM: begin
                    if (mem_ack) begin
                        r_state        <= S_RESPOND;
                        r_mem_request  <= make_req(CMD_NOP, '0);
                        r_mem_wdata    <= '0;
                        r_cpu_done     <= 1'b1;
                        r_cache_change <= make_req(CMD_WRITE, r_addr);
                    end
                end
                S_RESPOND: begin
                    r_state        <= S_IDLE;
                    r_cpu_ready    <= 1'b1;
                    r_cpu_done     <= 1'b0;
                    r_cache_change <= make_req(CMD_NOP, '0);
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cpu_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_ready    = r_cpu_ready;
    assign cpu_done     = r_cpu_done;
    assign cpu_rdata    = r_cpu_rdata;
    assign mem_request  = r_mem_request;
    assign mem_wdata    = r_mem_wdata;
    assign cache_change = r_cache_change;

endmodule
